// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer DDR scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package fb_pkg;

  // Default sizing; the scheduler takes these as parameter defaults
  localparam int DEF_BURST_LEN    = 256;
  localparam int DEF_FRAME_BURSTS = 2400;
  localparam int DEF_GAP_CYC      = 2;
  localparam int DEF_STARVE_MAX   = 4;

  // DDR address split: one buffer-select bit above a 14-bit burst index
  localparam int ADDR_W       = 15;
  localparam int IDX_W        = 14;
  localparam int ADDR_BUF_BIT = 14;

  // Burst pointers need one extra bit so "frame complete" (== FRAME_BURSTS) fits
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ACK  = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic buf_sel,
                                                  input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_BUF_BIT] = buf_sel;
    a[IDX_W-1:0]    = idx;
    return a;
  endfunction

endpackage

// File: rtl/fb_sync_edge.sv
// Brings an asynchronous vsync into clk: 2-flop synchronizer, level and rising-edge pulse.
// Latency: level 2 clk after the async edge, one-cycle rise pulse alongside the first high level.
// Backpressure: none; a free-running observer of the input.
module fb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Two synchronizer stages plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/fb_ddr_sched.sv
// Shares one DDR controller port between capture writes and display reads, ping-pong frame buffers.
// Latency: eligibility in IDLE -> strobe next cycle; ack -> data window next cycle.
// Backpressure: ACK waits indefinitely on sys_rdyn; one burst in flight, reads win unless writes starve.
module fb_ddr_sched
  import fb_pkg::*;
#(
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter int GAP_CYC      = DEF_GAP_CYC,
  parameter int STARVE_MAX   = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              in_half,
  input  logic              out_half,
  input  logic              in_vsync,
  input  logic              out_vsync,
  input  logic              sys_rdyn,
  output logic [ADDR_W-1:0] sys_addr,
  output logic              sys_adsn,
  output logic              sys_r_wn,
  output logic              rd,
  output logic              wr,
  output logic              busy
);

  localparam int CNT_W = 16;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  localparam logic [PTR_W-1:0] FRAME_END  = PTR_W'(FRAME_BURSTS);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

  logic in_active;
  logic in_rise;
  logic out_active;
  logic out_rise;

  fb_sync_edge u_in_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (in_vsync),
    .level    (in_active),
    .rise     (in_rise)
  );

  fb_sync_edge u_out_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (out_vsync),
    .level    (out_active),
    .rise     (out_rise)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wbuf;
  logic             rbuf;
  logic             done_buf;
  logic [ST_W-1:0]  starve;
  logic             dir_read;
  logic             ptr_clr;

  logic we;
  logic re;
  logic grant_rd;
  logic grant_wr;
  logic grant;
  logic data_last;
  logic gap_last;
  logic burst_dir;
  logic clr_hit;

  logic adsn_nxt;
  logic rd_nxt;
  logic wr_nxt;
  logic busy_nxt;

  // Eligibility, arbitration and phase-end decode
  always_comb begin
    we        = in_active & in_half & (wr_ptr < FRAME_END);
    re        = out_active & ~out_half & (rd_ptr < FRAME_END);
    grant_rd  = (state == ST_IDLE) & init_done & re & ~(we & (starve >= STARVE_LIM));
    grant_wr  = (state == ST_IDLE) & init_done & we & ~grant_rd;
    grant     = grant_rd | grant_wr;
    data_last = (state == ST_DATA) && (cnt == DATA_LAST);
    gap_last  = (state == ST_GAP) && (cnt == GAP_LAST);
    // Direction of the burst being granted or already in flight
    burst_dir = grant ? grant_rd : dir_read;
    // A vsync edge that clears the pointer owned by that burst
    clr_hit   = (in_rise & ~burst_dir) | (out_rise & burst_dir);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = ST_ACK;
      ST_ACK:  if (!sys_rdyn) state_nxt = ST_DATA;
      ST_DATA: if (data_last) state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode, computed from the next state so the outputs can be registered
  always_comb begin
    adsn_nxt = (state_nxt != ST_CMD);
    rd_nxt   = (state_nxt == ST_DATA) & ~dir_read;
    wr_nxt   = (state_nxt == ST_DATA) & dir_read;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Registered controller and FIFO strobes; command fields latch at grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_adsn <= 1'b1;
      sys_r_wn <= 1'b1;
      sys_addr <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sys_adsn <= adsn_nxt;
      rd       <= rd_nxt;
      wr       <= wr_nxt;
      busy     <= busy_nxt;
      if (grant_rd) begin
        sys_r_wn <= 1'b1;
        sys_addr <= pack_addr(rbuf, rd_ptr[IDX_W-1:0]);
      end else if (grant_wr) begin
        sys_r_wn <= 1'b0;
        sys_addr <= pack_addr(wbuf, wr_ptr[IDX_W-1:0]);
      end
    end
  end

  // Beat / gap counter, restarted on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_DATA || state == ST_GAP) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Burst direction, starvation guard and pointer-cleared-mid-burst flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_read <= 1'b0;
      starve   <= '0;
      ptr_clr  <= 1'b0;
    end else begin
      if (grant) dir_read <= grant_rd;
      if (grant_wr) begin
        starve <= '0;
      end else if (grant_rd && we && (starve < STARVE_LIM)) begin
        starve <= starve + ST_W'(1);
      end
      if (grant) begin
        ptr_clr <= clr_hit;
      end else if (state != ST_IDLE && clr_hit) begin
        ptr_clr <= 1'b1;
      end
    end
  end

  // Write side: frame pointer advance and buffer swap on input vsync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      wbuf     <= 1'b0;
      done_buf <= 1'b1;
    end else if (in_rise) begin
      wr_ptr <= '0;
      // Only a fully written frame is handed to the display side
      if (wr_ptr == FRAME_END) begin
        done_buf <= wbuf;
        wbuf     <= ~wbuf;
      end
    end else if (data_last && !dir_read && !ptr_clr) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Read side: pointer advance and pick up the last completed frame on output vsync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      rbuf   <= 1'b1;
    end else if (out_rise) begin
      rd_ptr <= '0;
      rbuf   <= done_buf;
    end else if (data_last && dir_read && !ptr_clr) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule
